// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder and other memory users:
// size encodings, responder state type, LFSR seed, and the pmem access
// functions. pmem_read/pmem_write use a small sparse byte store that lives
// in this package, so a pure-SystemVerilog build is self-contained.
package mem_pkg;

  localparam logic [1:0] MEM_SZ_B = 2'b00;
  localparam logic [1:0] MEM_SZ_H = 2'b01;
  localparam logic [1:0] MEM_SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } mem_resp_state_t;

  localparam logic [7:0] MEM_LFSR_SEED = 8'hA5;

  // Illegal size, or an address not aligned to the access size.
  function automatic logic mem_access_err(input logic [1:0] size, input logic [1:0] addr_lo);
    return (size == 2'b11) ||
           ((size == MEM_SZ_H) && addr_lo[0]) ||
           ((size == MEM_SZ_W) && (addr_lo != 2'b00));
  endfunction

  // Byte count handed to pmem_write for each legal size.
  function automatic int unsigned mem_size_len(input logic [1:0] size);
    case (size)
      MEM_SZ_B: return 1;
      MEM_SZ_H: return 2;
      MEM_SZ_W: return 4;
      default:  return 0;
    endcase
  endfunction

  // Little-endian sparse byte store; absent bytes read as zero.
  logic [7:0]  pmem_bytes [logic [31:0]];
  int unsigned pmem_write_calls;
  int unsigned pmem_last_len;

  function automatic int unsigned pmem_read(input int unsigned addr);
    int unsigned base;
    int unsigned word;
    base = addr & 32'hFFFF_FFFC;
    word = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (pmem_bytes.exists(base + i)) word[8*i +: 8] = pmem_bytes[base + i];
    end
    return word;
  endfunction

  function automatic void pmem_write(input int unsigned addr, input int unsigned data,
                                     input int unsigned len);
    for (int unsigned i = 0; i < len; i++) begin
      pmem_bytes[addr + i] = data[8*i +: 8];
    end
    pmem_write_calls = pmem_write_calls + 1;
    pmem_last_len    = len;
  endfunction

endpackage

// File: rtl/mem_delay_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) supplying 0..7 extra wait cycles.
// Advances once per accepted request; only used when MEM_RAND_DELAY_EN is set.
module mem_delay_lfsr
  import mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  output logic [2:0] delay
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Shift in the tap feedback only when a request is accepted.
  always_comb begin
    lfsr_d = lfsr_q;
    if (step) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // Reset to the fixed seed so delay sequences are repeatable.
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= MEM_LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign delay = lfsr_q[2:0];

endmodule

// File: rtl/mem_resp_port.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY
// cycles, performs the access through pmem_read/pmem_write and holds the raw
// word (or an alignment error) until the requester takes it.
// Optional feature: MEM_RAND_DELAY_EN adds 0..7 pseudo-random wait cycles
// per request to stress requester stall handling.
module mem_resp_port
  import mem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [4:0] LAT_M1 = 5'(LATENCY - 1);

  mem_resp_state_t state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [31:0]     rsp_rdata_q;
  logic            accept;
  logic            do_access;
  logic            acc_err;
  logic [4:0]      load_cnt;

  assign accept = (state_q == IDLE) && req_valid;

`ifdef MEM_RAND_DELAY_EN
  logic [2:0] extra_delay;

  mem_delay_lfsr u_delay_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (accept),
    .delay (extra_delay)
  );

  assign load_cnt = LAT_M1 + {2'b00, extra_delay};
`else
  assign load_cnt = LAT_M1;
`endif

  // Next-state logic; the access operands are the _d values so that a
  // zero-wait request uses the fields being captured on the same edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    do_access   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (load_cnt == 5'd0) begin
            state_d     = RESP;
            cnt_d       = 5'd0;
            rsp_valid_d = 1'b1;
            do_access   = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = load_cnt;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 5'd1) begin
          state_d     = RESP;
          cnt_d       = 5'd0;
          rsp_valid_d = 1'b1;
          do_access   = 1'b1;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
    acc_err   = mem_access_err(size_d, addr_d[1:0]);
    rsp_err_d = do_access ? acc_err : rsp_err_q;
  end

  // State update; the memory call lives here so it fires exactly once on the
  // RESP-entry edge and never while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      if (do_access) begin
        if (acc_err || we_d) rsp_rdata_q <= 32'd0;
        else                 rsp_rdata_q <= pmem_read(addr_d);
        if (!acc_err && we_d) pmem_write(addr_d, wdata_d, mem_size_len(size_d));
      end
    end
  end

  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_resp_port.sv
// Bench for mem_resp_port: three instances (LATENCY 1, 3, 4) sharing one
// memory; expected responses come from a local byte model and are queued
// when each request is driven.
module tb_mem_resp_port;

`ifdef MEM_RAND_DELAY_EN
  localparam int EXTRA = 7;
`else
  localparam int EXTRA = 0;
`endif

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [1:0]  req_size  [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  exp_t        sb [$];
  logic [7:0]  ref_mem [logic [31:0]];
  int          checks;
  int          errors;

  mem_resp_port #(.LATENCY(1)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  mem_resp_port #(.LATENCY(3)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  mem_resp_port #(.LATENCY(4)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_size(req_size[2]), .req_addr(req_addr[2]),
    .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int idx);
    return (idx == 0) ? 1 : (idx == 1) ? 3 : 4;
  endfunction

  // Reference memory: applies a store / produces a load result and error flag.
  function automatic exp_t model_access(input logic we, input logic [1:0] sz,
                                        input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    int          len;
    logic [31:0] base;
    e.err   = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    e.rdata = 32'd0;
    if (!e.err) begin
      if (we) begin
        len = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        for (int i = 0; i < len; i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
      end else begin
        base = {a[31:2], 2'b00};
        for (int i = 0; i < 4; i++)
          if (ref_mem.exists(base + 32'(i))) e.rdata[8*i +: 8] = ref_mem[base + 32'(i)];
      end
    end
    return e;
  endfunction

  // Drives one request with rsp_ready held high, pushes its expectation, and
  // returns what came back plus the accept-to-valid latency in cycles.
  task automatic run_txn(input int idx, input logic we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat,
                         output logic tmo);
    int n;
    sb.push_back(model_access(we, sz, a, wd));
    tmo = 1'b0; lat = 0; rd = 32'd0; er = 1'b0;
    @(negedge clk);
    req_we[idx] = we; req_size[idx] = sz; req_addr[idx] = a; req_wdata[idx] = wd;
    req_valid[idx] = 1'b1; rsp_ready[idx] = 1'b1;
    n = 0;
    while (req_ready[idx] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (req_ready[idx] !== 1'b1) begin tmo = 1'b1; req_valid[idx] = 1'b0; return; end
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    do begin @(negedge clk); lat++; end while (rsp_valid[idx] !== 1'b1 && lat < 40);
    if (rsp_valid[idx] !== 1'b1) begin tmo = 1'b1; return; end
    rd = rsp_rdata[idx]; er = rsp_err[idx];
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (req_ready[i] !== 1'b0 || rsp_valid[i] !== 1'b0 || rsp_err[i] !== 1'b0 || rsp_rdata[i] !== 32'd0) begin
        errors++;
        $display("[TB] FAIL reset_vals dut%0d: got ready=%b valid=%b err=%b rdata=%h want 0 0 0 0",
                 i, req_ready[i], rsp_valid[i], rsp_err[i], rsp_rdata[i]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (req_ready[i] !== 1'b1) begin
        errors++; $display("[TB] FAIL reset_ready dut%0d: got %b want 1", i, req_ready[i]);
      end
    end
  endtask

  task automatic test_word_l1();
    logic [31:0] rd; logic er, tmo; int lat; int unsigned wc; exp_t e;
    wc = mem_pkg::pmem_write_calls;
    run_txn(0, 1'b1, 2'b10, 32'h8000_0100, 32'hDEADBEEF, rd, er, lat, tmo);
    e = sb.pop_front();
    checks++;
    if (tmo || lat < 1 || lat > 1 + EXTRA) begin
      errors++; $display("[TB] FAIL st_word_lat: got %0d (timeout=%b) want 1..%0d", lat, tmo, 1 + EXTRA);
    end
    checks++;
    if (er !== e.err || rd !== e.rdata) begin
      errors++; $display("[TB] FAIL st_word_rsp: got err=%b rdata=%h want err=%b rdata=%h", er, rd, e.err, e.rdata);
    end
    checks++;
    if (mem_pkg::pmem_write_calls - wc != 1 || mem_pkg::pmem_last_len != 4) begin
      errors++; $display("[TB] FAIL st_word_write: got calls=%0d len=%0d want 1 4",
                         mem_pkg::pmem_write_calls - wc, mem_pkg::pmem_last_len);
    end
    run_txn(0, 1'b0, 2'b10, 32'h8000_0100, 32'd0, rd, er, lat, tmo);
    e = sb.pop_front();
    checks++;
    if (tmo || lat < 1 || lat > 1 + EXTRA) begin
      errors++; $display("[TB] FAIL ld_word_lat: got %0d (timeout=%b) want 1..%0d", lat, tmo, 1 + EXTRA);
    end
    checks++;
    if (er !== e.err || rd !== e.rdata) begin
      errors++; $display("[TB] FAIL ld_word_rsp: got err=%b rdata=%h want err=%b rdata=%h", er, rd, e.err, e.rdata);
    end
  endtask

  task automatic test_byte_half();
    logic [31:0] rd; logic er, tmo; int lat; int unsigned wc; exp_t e;
    run_txn(0, 1'b1, 2'b10, 32'h8000_0100, 32'h0000_0000, rd, er, lat, tmo);
    e = sb.pop_front();
    wc = mem_pkg::pmem_write_calls;
    run_txn(0, 1'b1, 2'b00, 32'h8000_0101, 32'hFFFF_FF5A, rd, er, lat, tmo);
    e = sb.pop_front();
    checks++;
    if (tmo || er !== e.err || mem_pkg::pmem_write_calls - wc != 1 || mem_pkg::pmem_last_len != 1) begin
      errors++; $display("[TB] FAIL st_byte: got err=%b calls=%0d len=%0d want err=0 calls=1 len=1",
                         er, mem_pkg::pmem_write_calls - wc, mem_pkg::pmem_last_len);
    end
    wc = mem_pkg::pmem_write_calls;
    run_txn(0, 1'b1, 2'b01, 32'h8000_0102, 32'hFFFF_1234, rd, er, lat, tmo);
    e = sb.pop_front();
    checks++;
    if (tmo || er !== e.err || mem_pkg::pmem_write_calls - wc != 1 || mem_pkg::pmem_last_len != 2) begin
      errors++; $display("[TB] FAIL st_half: got err=%b calls=%0d len=%0d want err=0 calls=1 len=2",
                         er, mem_pkg::pmem_write_calls - wc, mem_pkg::pmem_last_len);
    end
    run_txn(0, 1'b0, 2'b10, 32'h8000_0100, 32'd0, rd, er, lat, tmo);
    e = sb.pop_front();
    checks++;
    if (tmo || er !== 1'b0 || rd !== e.rdata || rd !== 32'h1234_5A00) begin
      errors++; $display("[TB] FAIL ld_merged: got err=%b rdata=%h want err=0 rdata=12345a00", er, rd);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic er, tmo; int lat; int unsigned wc; exp_t e;
    run_txn(0, 1'b0, 2'b01, 32'h8000_0001, 32'd0, rd, er, lat, tmo);
    e = sb.pop_front();
    checks++;
    if (tmo || er !== e.err || rd !== e.rdata || er !== 1'b1) begin
      errors++; $display("[TB] FAIL ld_half_mis: got err=%b rdata=%h want err=1 rdata=0", er, rd);
    end
    wc = mem_pkg::pmem_write_calls;
    run_txn(0, 1'b1, 2'b10, 32'h8000_0102, 32'hFFFF_FFFF, rd, er, lat, tmo);
    e = sb.pop_front();
    checks++;
    if (tmo || er !== 1'b1 || rd !== 32'd0 || mem_pkg::pmem_write_calls != wc) begin
      errors++; $display("[TB] FAIL st_word_mis: got err=%b rdata=%h calls=%0d want err=1 rdata=0 calls=0",
                         er, rd, mem_pkg::pmem_write_calls - wc);
    end
    run_txn(0, 1'b0, 2'b10, 32'h8000_0100, 32'd0, rd, er, lat, tmo);
    e = sb.pop_front();
    checks++;
    if (tmo || er !== e.err || rd !== e.rdata) begin
      errors++; $display("[TB] FAIL mem_unchanged: got err=%b rdata=%h want err=%b rdata=%h", er, rd, e.err, e.rdata);
    end
    run_txn(0, 1'b0, 2'b11, 32'h8000_0100, 32'd0, rd, er, lat, tmo);
    e = sb.pop_front();
    checks++;
    if (tmo || er !== 1'b1 || rd !== 32'd0) begin
      errors++; $display("[TB] FAIL size_illegal: got err=%b rdata=%h want err=1 rdata=0", er, rd);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er, tmo; int lat; exp_t e;
    run_txn(1, 1'b1, 2'b10, 32'h8000_0180, 32'hA5A5_1234, rd, er, lat, tmo);
    e = sb.pop_front();
    sb.push_back(model_access(1'b0, 2'b10, 32'h8000_0180, 32'd0));
    @(negedge clk);
    req_we[1] = 1'b0; req_size[1] = 2'b10; req_addr[1] = 32'h8000_0180; req_wdata[1] = 32'd0;
    req_valid[1] = 1'b1; rsp_ready[1] = 1'b0;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (rsp_valid[1] !== 1'b1 && lat < 40);
    e = sb.pop_front();
    checks++;
    if (rsp_valid[1] !== 1'b1 || lat < 3 || lat > 3 + EXTRA) begin
      errors++; $display("[TB] FAIL bp_lat: got %0d want 3..%0d", lat, 3 + EXTRA);
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== e.rdata || rsp_err[1] !== e.err || req_ready[1] !== 1'b0) begin
        errors++; $display("[TB] FAIL bp_hold c%0d: got valid=%b rdata=%h err=%b ready=%b want 1 %h %b 0",
                           c, rsp_valid[1], rsp_rdata[1], rsp_err[1], req_ready[1], e.rdata, e.err);
      end
      @(negedge clk);
    end
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0) begin
      errors++; $display("[TB] FAIL bp_release: got ready=%b valid=%b want 1 0", req_ready[1], rsp_valid[1]);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic er, tmo; int lat; int unsigned wc; exp_t e;
    run_txn(2, 1'b1, 2'b10, 32'h8000_0300, 32'h1122_3344, rd, er, lat, tmo);
    e = sb.pop_front();
    run_txn(2, 1'b0, 2'b10, 32'h8000_0300, 32'd0, rd, er, lat, tmo);
    e = sb.pop_front();
    checks++;
    if (tmo || lat < 4 || lat > 4 + EXTRA || rd !== e.rdata) begin
      errors++; $display("[TB] FAIL l4_load: got lat=%0d rdata=%h want lat 4..%0d rdata=%h", lat, rd, 4 + EXTRA, e.rdata);
    end
    wc = mem_pkg::pmem_write_calls;
    @(negedge clk);
    req_we[2] = 1'b1; req_size[2] = 2'b10; req_addr[2] = 32'h8000_0300; req_wdata[2] = 32'hCAFE_F00D;
    req_valid[2] = 1'b1; rsp_ready[2] = 1'b1;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid[2] !== 1'b0 || rsp_rdata[2] !== 32'd0 || rsp_err[2] !== 1'b0 || req_ready[2] !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_wait_vals: got valid=%b rdata=%h err=%b ready=%b want 0 0 0 0",
                         rsp_valid[2], rsp_rdata[2], rsp_err[2], req_ready[2]);
    end
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid[2] !== 1'b0 || req_ready[2] !== 1'b1) begin
        errors++; $display("[TB] FAIL rst_wait_idle c%0d: got valid=%b ready=%b want 0 1", c, rsp_valid[2], req_ready[2]);
      end
    end
    checks++;
    if (mem_pkg::pmem_write_calls != wc) begin
      errors++; $display("[TB] FAIL rst_wait_nowrite: got calls=%0d want 0", mem_pkg::pmem_write_calls - wc);
    end
    run_txn(2, 1'b0, 2'b10, 32'h8000_0300, 32'd0, rd, er, lat, tmo);
    e = sb.pop_front();
    checks++;
    if (tmo || rd !== e.rdata || rd !== 32'h1122_3344) begin
      errors++; $display("[TB] FAIL rst_wait_olddata: got rdata=%h want 11223344", rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, wd; logic er, tmo, we; logic [1:0] sz; int lat; exp_t e;
    for (int n = 0; n < 100; n++) begin
      a  = 32'h8000_0200 + 32'($urandom_range(0, 31));
      sz = 2'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      run_txn(1, we, sz, a, wd, rd, er, lat, tmo);
      e = sb.pop_front();
      checks++;
      if (tmo || lat < 3 || lat > 3 + EXTRA) begin
        errors++; $display("[TB] FAIL rand_lat n%0d: got %0d (timeout=%b) want 3..%0d", n, lat, tmo, 3 + EXTRA);
      end
      checks++;
      if (rd !== e.rdata || er !== e.err) begin
        errors++; $display("[TB] FAIL rand_rsp n%0d: got err=%b rdata=%h want err=%b rdata=%h", n, er, rd, e.err, e.rdata);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_size[i] = 2'b00;
      req_addr[i] = 32'd0; req_wdata[i] = 32'd0; rsp_ready[i] = 1'b0;
    end
    test_reset();
    test_word_l1();
    test_byte_half();
    test_misalign();
    test_backpressure();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
